// File: rtl/sobel_edge_stats_pkg.sv
// Shared types and width helpers for the Sobel edge statistics block.
package sobel_edge_stats_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int xw(input int img_width);
    return cw(img_width);
  endfunction

  function automatic int yw(input int img_height);
    return cw(img_height);
  endfunction

  // Column counter must also hold the saturated value IMG_WIDTH.
  function automatic int xcw(input int img_width);
    return cw(img_width + 1);
  endfunction

endpackage

// File: rtl/sobel_edge_stats_coord.sv
// Frame position tracking: x/y counters, line-length checking and frame
// done/abort strobes for the current beat.
module sobel_edge_stats_coord
  import sobel_edge_stats_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int XCW        = xcw(IMG_WIDTH),
  localparam int YW         = yw(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable_i,
  input  logic           valid_i,
  input  logic           tlast_i,
  input  logic           tuser_i,
  output logic           acc_o,
  output logic           sof_o,
  output logic [XCW-1:0] x_o,
  output logic [YW-1:0]  y_o,
  output logic           line_err_q_o,
  output logic           line_err_o,
  output logic           done_o,
  output logic           abort_o
);

  state_e         state_q, state_d;
  logic [XCW-1:0] x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           lerr_q, lerr_d;
  logic           beat, active, beat_err;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lerr_d  = lerr_q;

    beat    = valid_i && enable_i;
    active  = (state_q == ST_ACTIVE);
    sof_o   = beat && tuser_i;
    acc_o   = sof_o || (beat && active);
    abort_o = sof_o && active;
    x_o     = sof_o ? '0 : x_q;
    y_o     = sof_o ? '0 : y_q;
    done_o  = acc_o && tlast_i && (int'(y_o) == IMG_HEIGHT - 1);

    beat_err     = tlast_i ? (int'(x_o) != IMG_WIDTH - 1) : (int'(x_o) == IMG_WIDTH - 1);
    line_err_q_o = lerr_q;
    line_err_o   = (sof_o ? 1'b0 : lerr_q) | beat_err;

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (acc_o) begin
      state_d = done_o ? ST_IDLE : ST_ACTIVE;
      lerr_d  = line_err_o;
      if (tlast_i) begin
        x_d = '0;
        y_d = done_o ? '0 : y_o + 1'b1;
      end else begin
        x_d = (int'(x_o) == IMG_WIDTH) ? x_o : x_o + 1'b1;
        y_d = y_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lerr_q  <= lerr_d;
    end
  end

endmodule

// File: rtl/sobel_edge_stats.sv
// Sobel edge stream consumer: one-cycle pass-through plus per-frame edge count,
// bounding box and geometry checks, published as a one-cycle stat_valid record.
module sobel_edge_stats
  import sobel_edge_stats_pkg::*;
#(
  parameter  int DATA_WIDTH = 10,
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int CNT_W      = 20,
  localparam int XW         = xw(IMG_WIDTH),
  localparam int YW         = yw(IMG_HEIGHT),
  localparam int XCW        = xcw(IMG_WIDTH)
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] edge_level,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  stat_valid,
  output logic [CNT_W-1:0]      stat_edge_count,
  output logic [XW-1:0]         stat_x_min,
  output logic [XW-1:0]         stat_x_max,
  output logic [YW-1:0]         stat_y_min,
  output logic [YW-1:0]         stat_y_max,
  output logic                  stat_empty,
  output logic                  stat_line_err,
  output logic                  stat_frame_err
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [XW-1:0]    x_min;
    logic [XW-1:0]    x_max;
    logic [YW-1:0]    y_min;
    logic [YW-1:0]    y_max;
  } acc_t;

  localparam acc_t ACC_INIT = '{cnt: '0, x_min: '1, x_max: '0, y_min: '1, y_max: '0};

  logic                  acc, sof, done, abort, line_err_q, line_err, is_edge;
  logic [XCW-1:0]        x;
  logic [YW-1:0]         y;
  logic [XW-1:0]         px;
  acc_t                  acc_q, acc_d, acc_base, rpt_q, stat_q;
  logic                  rpt_lerr_q, rpt_ferr_q, rpt_pend_q;
  logic                  stat_valid_q, stat_empty_q, stat_lerr_q, stat_ferr_q;
  logic [DATA_WIDTH+2:0] pt_q;

  sobel_edge_stats_coord #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_coord (
    .clk         (pixel_clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .valid_i     (s_axis_tvalid),
    .tlast_i     (s_axis_tlast),
    .tuser_i     (s_axis_tuser),
    .acc_o       (acc),
    .sof_o       (sof),
    .x_o         (x),
    .y_o         (y),
    .line_err_q_o(line_err_q),
    .line_err_o  (line_err),
    .done_o      (done),
    .abort_o     (abort)
  );

  always_comb begin
    acc_base = sof ? ACC_INIT : acc_q;
    acc_d    = acc_base;
    px       = x[XW-1:0];
    is_edge  = acc && (s_axis_tdata >= edge_level) &&
               (int'(x) < IMG_WIDTH) && (int'(y) < IMG_HEIGHT);
    if (is_edge) begin
      if (acc_base.cnt != '1)    acc_d.cnt   = acc_base.cnt + 1'b1;
      if (px < acc_base.x_min)   acc_d.x_min = px;
      if (px > acc_base.x_max)   acc_d.x_max = px;
      if (y < acc_base.y_min)    acc_d.y_min = y;
      if (y > acc_base.y_max)    acc_d.y_max = y;
    end
  end

  // An early tuser overwrites the accumulators on the same edge, so the
  // finished frame is snapshotted here and published one edge later.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      rpt_q      <= '0;
      rpt_lerr_q <= 1'b0;
      rpt_ferr_q <= 1'b0;
      rpt_pend_q <= 1'b0;
    end else begin
      if (acc) acc_q <= acc_d;
      rpt_pend_q <= abort || done;
      if (abort) begin
        rpt_q      <= acc_q;
        rpt_lerr_q <= line_err_q;
        rpt_ferr_q <= 1'b1;
      end else if (done) begin
        rpt_q      <= acc_d;
        rpt_lerr_q <= line_err;
        rpt_ferr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_valid_q <= 1'b0;
      stat_empty_q <= 1'b0;
      stat_lerr_q  <= 1'b0;
      stat_ferr_q  <= 1'b0;
      stat_q       <= '0;
      pt_q         <= '0;
    end else begin
      pt_q         <= {s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tdata};
      stat_valid_q <= rpt_pend_q;
      if (rpt_pend_q) begin
        stat_empty_q <= (rpt_q.cnt == '0);
        stat_q       <= (rpt_q.cnt == '0) ? '0 : rpt_q;
        stat_lerr_q  <= rpt_lerr_q;
        stat_ferr_q  <= rpt_ferr_q;
      end
    end
  end

  assign {m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tdata} = pt_q;
  assign stat_valid      = stat_valid_q;
  assign stat_edge_count = stat_q.cnt;
  assign stat_x_min      = stat_q.x_min;
  assign stat_x_max      = stat_q.x_max;
  assign stat_y_min      = stat_q.y_min;
  assign stat_y_max      = stat_q.y_max;
  assign stat_empty      = stat_empty_q;
  assign stat_line_err   = stat_lerr_q;
  assign stat_frame_err  = stat_ferr_q;

endmodule

// File: tb/tb_sobel_edge_stats.sv
// Self-checking bench for sobel_edge_stats on an 8x4 image, edge_level 512.
module tb_sobel_edge_stats;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 10;
  localparam int CW = 20;
  localparam int LEVEL = 512;

  logic          pixel_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic [DW-1:0] edge_level = DW'(LEVEL);
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tlast  = 1'b0;
  logic          s_tuser  = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast, m_tuser, m_tvalid;
  logic          stat_valid, stat_empty, stat_line_err, stat_frame_err;
  logic [CW-1:0] stat_edge_count;
  logic [2:0]    stat_x_min, stat_x_max;
  logic [1:0]    stat_y_min, stat_y_max;

  sobel_edge_stats #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)
  ) dut (
    .pixel_clk      (pixel_clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .edge_level     (edge_level),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .stat_valid     (stat_valid),
    .stat_edge_count(stat_edge_count),
    .stat_x_min     (stat_x_min),
    .stat_x_max     (stat_x_max),
    .stat_y_min     (stat_y_min),
    .stat_y_max     (stat_y_max),
    .stat_empty     (stat_empty),
    .stat_line_err  (stat_line_err),
    .stat_frame_err (stat_frame_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int cnt, xmin, xmax, ymin, ymax;
    int empty, lerr, ferr;
    int cyc;
  } rep_t;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  bit   gaps = 1'b0;
  bit   pt_on = 1'b0;
  bit   pt_have = 1'b0;
  logic [DW+2:0] pt_prev;
  rep_t rq[$];
  rep_t mon_r;

  logic [DW-1:0] pix [H][10];
  int            len [H];

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Record every cycle stat_valid is high; a stretched pulse leaves extra entries.
  always @(negedge pixel_clk) begin
    if (stat_valid === 1'b1) begin
      mon_r.cnt   = int'(stat_edge_count);
      mon_r.xmin  = int'(stat_x_min);
      mon_r.xmax  = int'(stat_x_max);
      mon_r.ymin  = int'(stat_y_min);
      mon_r.ymax  = int'(stat_y_max);
      mon_r.empty = int'(stat_empty);
      mon_r.lerr  = int'(stat_line_err);
      mon_r.ferr  = int'(stat_frame_err);
      mon_r.cyc   = cyc;
      rq.push_back(mon_r);
    end
  end

  always @(negedge pixel_clk) begin
    if (pt_on && pt_have)
      check("passthru", 32'({m_tuser, m_tlast, m_tvalid, m_tdata}), 32'(pt_prev));
    pt_prev = {s_tuser, s_tlast, s_tvalid, s_tdata};
    pt_have = pt_on;
  end

  // Expected statistics straight from the frame description: rows 0..n_full-1
  // are complete lines, then part_len beats of row n_full with no tlast (-1: none).
  function automatic rep_t model(input int n_full, input int part_len);
    rep_t e;
    int   n;
    e = '{cnt: 0, xmin: W, xmax: -1, ymin: H, ymax: -1,
          empty: 0, lerr: 0, ferr: (part_len >= 0) ? 1 : 0, cyc: 0};
    for (int r = 0; r < n_full + ((part_len >= 0) ? 1 : 0); r++) begin
      n = (r < n_full) ? len[r] : part_len;
      if (r < n_full && len[r] != W) e.lerr = 1;
      if (r == n_full && part_len >= W) e.lerr = 1;
      for (int c = 0; c < n; c++) begin
        if (c < W && int'(pix[r][c]) >= LEVEL) begin
          e.cnt++;
          if (c < e.xmin) e.xmin = c;
          if (c > e.xmax) e.xmax = c;
          if (r < e.ymin) e.ymin = r;
          if (r > e.ymax) e.ymax = r;
        end
      end
    end
    if (e.cnt == 0) begin
      e.empty = 1;
      e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
    end
    return e;
  endfunction

  task automatic clear_frame(input int v);
    for (int r = 0; r < H; r++) begin
      len[r] = W;
      for (int c = 0; c < 10; c++) pix[r][c] = DW'(v);
    end
  endtask

  task automatic rand_frame();
    for (int r = 0; r < H; r++) begin
      len[r] = W;
      for (int c = 0; c < 10; c++)
        pix[r][c] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(512, 1023))
                                                 : DW'($urandom_range(0, 511));
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic u, output int e);
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      s_tdata  = DW'($urandom);
      s_tlast  = 1'($urandom);
      s_tuser  = 1'($urandom);
      @(posedge pixel_clk); #1;
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    @(posedge pixel_clk); #1;
    e = cyc;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int n_full, input int part_len, output int first_e, output int last_e);
    int e;
    bit first;
    first = 1'b1;
    first_e = 0;
    last_e = 0;
    for (int r = 0; r < n_full; r++)
      for (int c = 0; c < len[r]; c++) begin
        drive_beat(pix[r][c], c == len[r] - 1, first, e);
        if (first) first_e = e;
        first = 1'b0;
        last_e = e;
      end
    for (int c = 0; c < part_len; c++) begin
      drive_beat(pix[n_full][c], 1'b0, first, e);
      if (first) first_e = e;
      first = 1'b0;
      last_e = e;
    end
  endtask

  task automatic expect_report(input string tag, input rep_t e, input int exp_cyc);
    rep_t r;
    int   waited;
    waited = 0;
    while (rq.size() == 0 && waited < 8) begin
      @(negedge pixel_clk);
      waited++;
    end
    check({tag, "_seen"}, 32'(rq.size() != 0), 32'(1));
    if (rq.size() == 0) return;
    r = rq.pop_front();
    check({tag, "_count"}, 32'(r.cnt), 32'(e.cnt));
    check({tag, "_box"}, {8'(r.xmin), 8'(r.xmax), 8'(r.ymin), 8'(r.ymax)},
                         {8'(e.xmin), 8'(e.xmax), 8'(e.ymin), 8'(e.ymax)});
    check({tag, "_flags"}, 32'(r.empty * 4 + r.lerr * 2 + r.ferr),
                           32'(e.empty * 4 + e.lerr * 2 + e.ferr));
    check({tag, "_cycle"}, 32'(r.cyc), 32'(exp_cyc));
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    repeat (ncyc) @(negedge pixel_clk);
    check(tag, 32'(rq.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rep_t e, e1;
    int   f, l, f2, l2, d;

    enable = 1'b1;
    repeat (2) @(negedge pixel_clk);
    check("reset_m", 32'({m_tuser, m_tlast, m_tvalid, m_tdata}), 32'(0));
    check("reset_stat", 32'({stat_valid, stat_empty, stat_line_err, stat_frame_err, stat_edge_count}), 32'(0));
    check("reset_box", 32'({stat_x_min, stat_x_max, stat_y_min, stat_y_max}), 32'(0));
    rst_n = 1'b1;

    // Single edge pixel.
    clear_frame(0);
    pix[2][3] = 10'd1023;
    send_frame(H, 0, f, l);
    expect_report("single", model(H, -1), l + 1);
    expect_quiet("single_once", 3);

    clear_frame(0);
    send_frame(H, 0, f, l);
    expect_report("zero", model(H, -1), l + 1);

    clear_frame(1023);
    send_frame(H, 0, f, l);
    expect_report("full", model(H, -1), l + 1);

    // Threshold boundary: 512 is an edge, 511 is not.
    clear_frame(0);
    pix[1][6] = 10'd512;
    pix[3][1] = 10'd511;
    send_frame(H, 0, f, l);
    expect_report("level", model(H, -1), l + 1);

    // Short row 1, then a clean frame clears line_err.
    clear_frame(0);
    pix[0][4] = 10'd900;
    len[1] = 6;
    send_frame(H, 0, f, l);
    expect_report("short_line", model(H, -1), l + 1);
    clear_frame(0);
    pix[3][7] = 10'd700;
    send_frame(H, 0, f, l);
    expect_report("clean_after", model(H, -1), l + 1);

    // Early tuser on row 2 after three edge pixels.
    clear_frame(0);
    pix[0][1] = 10'd1023;
    pix[1][5] = 10'd1023;
    pix[2][2] = 10'd1023;
    send_frame(2, 4, f, l);
    e1 = model(2, 4);
    clear_frame(0);
    pix[0][0] = 10'd1023;
    send_frame(H, 0, f2, l2);
    expect_report("abort", e1, f2 + 1);
    expect_report("after_abort", model(H, -1), l2 + 1);
    expect_quiet("abort_quiet", 3);

    // Randomised frames with idle gaps and occasional odd line lengths.
    gaps = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_frame();
      if ($urandom_range(0, 1) == 0) len[$urandom_range(0, H - 1)] = $urandom_range(5, 10);
      send_frame(H, 0, f, l);
      expect_report($sformatf("rand%0d", i), model(H, -1), l + 1);
    end
    gaps = 1'b0;

    // enable dropped mid-frame: no report, pass-through unaffected.
    rand_frame();
    send_frame(2, 3, f, l);
    enable = 1'b0;
    pt_on = 1'b1;
    for (int i = 0; i < 8; i++)
      drive_beat(DW'($urandom), 1'($urandom), i == 2, d);
    pt_on = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++)
      drive_beat(10'd1023, i % 2 == 1, 1'b0, d);
    expect_quiet("enable_drop", 4);
    clear_frame(1023);
    send_frame(H, 0, f, l);
    expect_report("reenable", model(H, -1), l + 1);

    // Asynchronous reset mid-frame.
    rand_frame();
    send_frame(2, 2, f, l);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_m", 32'({m_tuser, m_tlast, m_tvalid, m_tdata}), 32'(0));
    check("rst_async_stat", 32'({stat_valid, stat_empty, stat_line_err, stat_frame_err, stat_edge_count}), 32'(0));
    check("rst_async_box", 32'({stat_x_min, stat_x_max, stat_y_min, stat_y_max}), 32'(0));
    repeat (2) @(negedge pixel_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      drive_beat(10'd1023, i % 8 == 7, 1'b0, d);
    expect_quiet("rst_ignore", 4);
    rand_frame();
    pix[1][2] = 10'd1000;
    send_frame(H, 0, f, l);
    expect_report("post_reset", model(H, -1), l + 1);
    expect_quiet("final_quiet", 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stats.md
Name: sobel_edge_stats

Overview:
Downstream consumer of the Sobel edge stream. Passes the stream through with a one-cycle register. Per frame, it counts edge pixels, tracks the edge bounding box and checks frame geometry. At frame end it publishes a one-cycle-qualified statistics record, which software or an ROI/auto-focus stage reads.

Parameters:
DATA_WIDTH, 10, pixel/edge data width
IMG_WIDTH, 640, expected pixels per line
IMG_HEIGHT, 480, expected lines per frame
CNT_W, 20, edge-count width; must hold IMG_WIDTH*IMG_HEIGHT

Ports:
pixel_clk  in  1  pixel clock, sole clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = accumulate statistics; 0 = statistics halted, pass-through only
edge_level  in  DATA_WIDTH  pixel is an edge when s_axis_tdata >= edge_level
s_axis_tdata  in  DATA_WIDTH  edge magnitude/binary pixel
s_axis_tlast  in  1  end of line
s_axis_tuser  in  1  start of frame (first pixel)
s_axis_tvalid  in  1  beat valid; no backpressure
m_axis_tdata/tlast/tuser/tvalid  out  DATA_WIDTH/1/1/1  pass-through, 1-cycle delay
stat_valid  out  1  one-cycle pulse: stat_* updated
stat_edge_count  out  CNT_W  edge pixels in frame, saturating
stat_x_min, stat_x_max  out  clog2(IMG_WIDTH)  edge bounding box columns
stat_y_min, stat_y_max  out  clog2(IMG_HEIGHT)  edge bounding box rows
stat_empty  out  1  frame contained no edge pixel
stat_line_err  out  1  at least one line length != IMG_WIDTH
stat_frame_err  out  1  frame ended early (tuser before last line completed)

Behaviour:
- Reset: all outputs 0, FSM IDLE, accumulators cleared. Reset mid-frame abandons the frame with no stat_valid.
- Pass-through: m_axis_* <= s_axis_* every clock, regardless of enable or state.
- FSM states:
  - IDLE: beats without tuser are ignored. A valid beat with tuser moves to ACTIVE; that beat is pixel (0,0) and is accumulated.
  - ACTIVE:
    - Each valid beat is at (x,y). Non-tlast beat: x <= x+1, with x saturating at IMG_WIDTH. tlast beat: x <= 0, y <= y+1.
    - tlast beat with y == IMG_HEIGHT-1: frame complete; go to IDLE and report.
- Edge accumulation applies when tdata >= edge_level and x < IMG_WIDTH and y < IMG_HEIGHT:
  - count <= count+1, saturating at 2^CNT_W-1
  - min/max updated per coordinate
  - per-frame init: x_min/y_min all-ones, x_max/y_max 0
- line_err is sticky per frame. It is set by:
  - a tlast beat with x != IMG_WIDTH-1, or
  - a non-tlast beat at x == IMG_WIDTH-1.
- Early tuser while ACTIVE:
  - the partial frame is reported with stat_frame_err=1;
  - the same beat restarts accumulation as pixel (0,0) of the new frame;
  - the FSM stays ACTIVE.
- Report timing and contents:
  - The final beat is sampled at edge k. Stat registers load, and stat_valid is high, from edge k+1 to edge k+2.
  - Reported values include the final beat.
  - If count == 0: stat_empty=1 and the box outputs are 0.
  - Stat registers hold until the next report.
- enable: when low, the FSM goes to IDLE at the next edge and the partial frame is discarded with no stat_valid. Accumulation resumes at the next tuser after enable rises.
- tvalid low: no state change; gaps are allowed anywhere.
- edge_level is sampled per beat; it is software-static in normal use.

Decomposition:
- Package sobel_edge_stats_pkg:
  - FSM state enum (IDLE, ACTIVE)
  - width helper functions: clog2-based XW and YW
- Sub-module sobel_edge_stats_coord:
  - x/y counters, x saturation, line_err detection
  - frame_done and frame_abort strobes
- Top module: accumulators, report registers, pass-through.

Test Plan:
Bench configuration for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=4, edge_level=512.
- Frame with the single pixel 1023 at (3,2) and all others 0 -> one stat_valid pulse two cycles after the final tlast; count=1, x_min=x_max=3, y_min=y_max=2, empty=0, errs=0.
- All-zero frame -> count=0, empty=1, box all 0; 8x4 frame with every pixel 1023 -> count=32, box (0,7,0,3).
- Row 1 terminated by tlast at x=5, other rows normal -> line_err=1, frame_err=0, stat_valid still at normal frame end; next clean frame -> line_err=0.
- tuser arriving on row 2 after 3 edge pixels -> stat_valid with frame_err=1, count=3. The tuser pixel, at 1023, is counted in the following frame's report, which shows count=1 and box (0,0,0,0).
- enable dropped mid-frame -> no stat_valid, and m_axis continues to equal s_axis delayed one cycle. Re-enable, then a full frame -> normal report.
- rst_n asserted mid-frame, asynchronous with pixel_clk -> outputs 0 immediately. Next tuser frame reports correctly; beats without tuser after reset are ignored.
